// File: rtl/bpi_flash_if.sv
`timescale 1ns/1ps
// BPI parallel NOR flash access sequencer: address latch, timed write/read strobes, recovery gap.
// Optional BPI_RD_INREG_EN registers the flash data bus and adds one READ cycle before capture.
module bpi_flash_if #(
    parameter int unsigned T_LATCH = 2,
    parameter int unsigned T_WR    = 3,
    parameter int unsigned T_RD    = 4,
    parameter int unsigned T_REC   = 1
) (
    input  logic        CLK,
    input  logic        RST_B,
    input  logic        CMD_VLD,
    output logic        CMD_RDY,
    input  logic        CMD_WR,
    input  logic [22:0] CMD_ADDR,
    input  logic [15:0] CMD_DATA,
    output logic [15:0] RD_DATA,
    output logic        RD_VLD,
    output logic        BUSY,
    output logic [20:0] BPI_AD_OUT,
    output logic        FPGA_A21,
    output logic        FPGA_A22,
    output logic        FCS_B,
    output logic        FLATCH_B,
    output logic        FOE_B,
    output logic        FWE_B,
    input  logic [15:0] CFG_DAT_IN,
    output logic [15:0] CFG_DAT_OUT,
    output logic        CFG_DAT_OE
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LATCH   = 3'd1;
    localparam logic [2:0] S_WRITE   = 3'd2;
    localparam logic [2:0] S_READ    = 3'd3;
    localparam logic [2:0] S_RECOVER = 3'd4;

`ifdef BPI_RD_INREG_EN
    localparam int unsigned T_RD_EFF = T_RD + 1;
`else
    localparam int unsigned T_RD_EFF = T_RD;
`endif

    localparam int unsigned T_MAX_A = (T_LATCH > T_WR) ? T_LATCH : T_WR;
    localparam int unsigned T_MAX_B = (T_RD_EFF > T_REC) ? T_RD_EFF : T_REC;
    localparam int unsigned T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int unsigned CNT_W   = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    logic [2:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             cmd_wr_q, cmd_wr_nxt;
    logic [20:0]      ad_nxt;
    logic             a21_nxt, a22_nxt;
    logic [15:0]      dout_nxt;
    logic [15:0]      rd_data_nxt;
    logic             rd_vld_nxt;
    logic             cmd_rdy_nxt, busy_nxt;
    logic             fcs_nxt, flatch_nxt, foe_nxt, fwe_nxt, oe_nxt;
    logic [15:0]      rd_src;

`ifdef BPI_RD_INREG_EN
    logic [15:0] din_q;

    // Flash data bus sampled every cycle; capture uses the registered copy.
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            din_q <= 16'h0000;
        end else begin
            din_q <= CFG_DAT_IN;
        end
    end

    assign rd_src = din_q;
`else
    assign rd_src = CFG_DAT_IN;
`endif

    // Next-state, counter and registered-output values.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        cmd_wr_nxt  = cmd_wr_q;
        ad_nxt      = BPI_AD_OUT;
        a21_nxt     = FPGA_A21;
        a22_nxt     = FPGA_A22;
        dout_nxt    = CFG_DAT_OUT;
        rd_data_nxt = RD_DATA;
        rd_vld_nxt  = 1'b0;

        case (state)
            S_IDLE: begin
                if (CMD_VLD && CMD_RDY) begin
                    state_nxt  = S_LATCH;
                    cnt_nxt    = CNT_W'(T_LATCH - 1);
                    cmd_wr_nxt = CMD_WR;
                    ad_nxt     = CMD_ADDR[20:0];
                    a21_nxt    = CMD_ADDR[21];
                    a22_nxt    = CMD_ADDR[22];
                    dout_nxt   = CMD_DATA;
                end
            end
            S_LATCH: begin
                if (cnt == '0) begin
                    state_nxt = cmd_wr_q ? S_WRITE : S_READ;
                    cnt_nxt   = cmd_wr_q ? CNT_W'(T_WR - 1) : CNT_W'(T_RD_EFF - 1);
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_WRITE: begin
                if (cnt == '0) begin
                    state_nxt = S_RECOVER;
                    cnt_nxt   = CNT_W'(T_REC - 1);
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_READ: begin
                if (cnt == '0) begin
                    state_nxt   = S_RECOVER;
                    cnt_nxt     = CNT_W'(T_REC - 1);
                    rd_data_nxt = rd_src;
                    rd_vld_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_RECOVER: begin
                if (cnt == '0) begin
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // Strobes are decoded from the state being entered so they line up with it.
        fcs_nxt     = !((state_nxt == S_LATCH) || (state_nxt == S_WRITE) || (state_nxt == S_READ));
        flatch_nxt  = (state_nxt != S_LATCH);
        foe_nxt     = (state_nxt != S_READ);
        fwe_nxt     = (state_nxt != S_WRITE);
        oe_nxt      = (state_nxt == S_WRITE);
        busy_nxt    = (state_nxt != S_IDLE);
        cmd_rdy_nxt = (state_nxt == S_IDLE);
    end

    // State, counter, command and output registers.
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            state       <= S_IDLE;
            cnt         <= '0;
            cmd_wr_q    <= 1'b0;
            BPI_AD_OUT  <= 21'h000000;
            FPGA_A21    <= 1'b0;
            FPGA_A22    <= 1'b0;
            CFG_DAT_OUT <= 16'h0000;
            RD_DATA     <= 16'h0000;
            RD_VLD      <= 1'b0;
            CMD_RDY     <= 1'b0;
            BUSY        <= 1'b0;
            FCS_B       <= 1'b1;
            FLATCH_B    <= 1'b1;
            FOE_B       <= 1'b1;
            FWE_B       <= 1'b1;
            CFG_DAT_OE  <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            cmd_wr_q    <= cmd_wr_nxt;
            BPI_AD_OUT  <= ad_nxt;
            FPGA_A21    <= a21_nxt;
            FPGA_A22    <= a22_nxt;
            CFG_DAT_OUT <= dout_nxt;
            RD_DATA     <= rd_data_nxt;
            RD_VLD      <= rd_vld_nxt;
            CMD_RDY     <= cmd_rdy_nxt;
            BUSY        <= busy_nxt;
            FCS_B       <= fcs_nxt;
            FLATCH_B    <= flatch_nxt;
            FOE_B       <= foe_nxt;
            FWE_B       <= fwe_nxt;
            CFG_DAT_OE  <= oe_nxt;
        end
    end

endmodule

// File: tb/tb_bpi_flash_if.sv
`timescale 1ns/1ps
// Directed bench for bpi_flash_if with a behavioural 85 ns flash read model.
module tb_bpi_flash_if;

    localparam int unsigned T_LATCH = 2;
    localparam int unsigned T_WR    = 3;
    localparam int unsigned T_REC   = 1;
`ifdef BPI_RD_INREG_EN
    localparam int unsigned RD_LAT  = 7;
`else
    localparam int unsigned RD_LAT  = 6;
`endif
    localparam int unsigned T_RD_EFF = RD_LAT - T_LATCH;
    localparam int unsigned SPACING  = RD_LAT + T_REC + 1;

    logic        CLK, RST_B;
    logic        CMD_VLD, CMD_RDY, CMD_WR;
    logic [22:0] CMD_ADDR;
    logic [15:0] CMD_DATA, RD_DATA;
    logic        RD_VLD, BUSY;
    logic [20:0] BPI_AD_OUT;
    logic        FPGA_A21, FPGA_A22;
    logic        FCS_B, FLATCH_B, FOE_B, FWE_B;
    logic [15:0] CFG_DAT_IN, CFG_DAT_OUT;
    logic        CFG_DAT_OE;

    bpi_flash_if #(.T_LATCH(2), .T_WR(3), .T_RD(4), .T_REC(1)) dut (
        .CLK(CLK), .RST_B(RST_B),
        .CMD_VLD(CMD_VLD), .CMD_RDY(CMD_RDY), .CMD_WR(CMD_WR),
        .CMD_ADDR(CMD_ADDR), .CMD_DATA(CMD_DATA),
        .RD_DATA(RD_DATA), .RD_VLD(RD_VLD), .BUSY(BUSY),
        .BPI_AD_OUT(BPI_AD_OUT), .FPGA_A21(FPGA_A21), .FPGA_A22(FPGA_A22),
        .FCS_B(FCS_B), .FLATCH_B(FLATCH_B), .FOE_B(FOE_B), .FWE_B(FWE_B),
        .CFG_DAT_IN(CFG_DAT_IN), .CFG_DAT_OUT(CFG_DAT_OUT), .CFG_DAT_OE(CFG_DAT_OE)
    );

    initial CLK = 1'b0;
    always #12 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Flash model: data valid 85 ns after FOE_B falls, 0xFFFF otherwise.
    realtime     t_fall = 0.0;
    logic [22:0] bus_addr;
    assign bus_addr = {FPGA_A22, FPGA_A21, BPI_AD_OUT};

    function automatic logic [15:0] flash_word(input logic [22:0] a);
        if (a == 23'h7F8000) return 16'h506B;
        return a[15:0] ^ 16'h1234;
    endfunction

    always @(negedge FOE_B) t_fall = $realtime;

    initial begin
        CFG_DAT_IN = 16'hFFFF;
        forever begin
            #1;
            CFG_DAT_IN = (!FOE_B && ($realtime - t_fall >= 85.0)) ? flash_word(bus_addr) : 16'hFFFF;
        end
    end

    // Strobe exclusivity and ready/busy consistency on every cycle.
    always @(negedge CLK) begin
        if (chk_en) begin
            check("oe_we_both_low", 32'(!FOE_B && !FWE_B), 32'd0);
            check("drive_while_oe", 32'(CFG_DAT_OE && !FOE_B), 32'd0);
            check("rdy_while_busy", 32'(CMD_RDY && BUSY), 32'd0);
        end
    end

    typedef struct {
        logic        wr;
        logic [22:0] addr;
        logic [15:0] data;
        logic [15:0] exp_rd;
        logic [20:0] exp_ad;
        logic        exp_a21;
        logic        exp_a22;
    } vec_t;

    // One command, observed cycle by cycle from the accept edge back to idle.
    task automatic run_cmd(input vec_t v, input string tag);
        int s, n_lat, n_we, n_oe, n_vld, vld_at, idle_at, waitc;
        logic addr_ok, dout_ok, fcs_ok;
        logic [15:0] rd_prev;
        rd_prev = RD_DATA;
        @(negedge CLK);
        CMD_VLD = 1'b1; CMD_WR = v.wr; CMD_ADDR = v.addr; CMD_DATA = v.data;
        waitc = 0;
        while (!CMD_RDY && waitc < 50) begin
            @(negedge CLK);
            waitc++;
        end
        check({tag, "_rdy"}, 32'(CMD_RDY), 32'd1);
        @(negedge CLK);
        CMD_VLD = 1'b0; CMD_WR = ~v.wr; CMD_ADDR = ~v.addr; CMD_DATA = ~v.data;
        n_lat = 0; n_we = 0; n_oe = 0; n_vld = 0; vld_at = -1; idle_at = -1;
        addr_ok = 1'b1; dout_ok = 1'b1; fcs_ok = 1'b1;
        s = 0;
        while (idle_at < 0 && s < 40) begin
            if (!FLATCH_B) n_lat++;
            if (!FWE_B) begin
                n_we++;
                if (CFG_DAT_OUT !== v.data || CFG_DAT_OE !== 1'b1) dout_ok = 1'b0;
            end
            if (!FOE_B) n_oe++;
            if (RD_VLD) begin n_vld++; vld_at = s; end
            if (BUSY && (FCS_B !== (FLATCH_B & FWE_B & FOE_B))) fcs_ok = 1'b0;
            if ({FPGA_A22, FPGA_A21, BPI_AD_OUT} !== {v.exp_a22, v.exp_a21, v.exp_ad}) addr_ok = 1'b0;
            if (!BUSY) idle_at = s;
            else begin
                @(negedge CLK);
                s++;
            end
        end
        check({tag, "_latch_cycles"}, 32'(n_lat), 32'(T_LATCH));
        check({tag, "_we_cycles"}, 32'(n_we), v.wr ? 32'(T_WR) : 32'd0);
        check({tag, "_oe_cycles"}, 32'(n_oe), v.wr ? 32'd0 : 32'(T_RD_EFF));
        check({tag, "_rdvld_count"}, 32'(n_vld), v.wr ? 32'd0 : 32'd1);
        check({tag, "_rdvld_latency"}, 32'(vld_at), v.wr ? 32'hFFFF_FFFF : 32'(RD_LAT));
        check({tag, "_idle_at"}, 32'(idle_at), 32'(T_LATCH + (v.wr ? T_WR : T_RD_EFF) + T_REC));
        check({tag, "_addr_held"}, 32'(addr_ok), 32'd1);
        check({tag, "_wdata"}, 32'(dout_ok), 32'd1);
        check({tag, "_fcs"}, 32'(fcs_ok), 32'd1);
        check({tag, "_rd_data"}, 32'(RD_DATA), v.wr ? 32'(rd_prev) : 32'(v.exp_rd));
    endtask

    vec_t vecs[8];

    initial begin : main
        int acc, cyc, n_vld, bad;
        int acc_at[3];

        vecs[0] = '{1'b1, 23'h7F8000, 16'hA5C3, 16'h0000, 21'h1F8000, 1'b1, 1'b1};
        vecs[1] = '{1'b0, 23'h7F8000, 16'h0000, 16'h506B, 21'h1F8000, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 23'h000001, 16'h0000, 16'h0000, 21'h000001, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 23'h000000, 16'h0000, 16'h1234, 21'h000000, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 23'h7FFFFF, 16'h0000, 16'hEDCB, 21'h1FFFFF, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 23'h200000, 16'hFFFF, 16'h0000, 21'h000000, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 23'h400000, 16'h0000, 16'h1234, 21'h000000, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 23'h2ABCDE, 16'h0000, 16'hAEEA, 21'h0ABCDE, 1'b1, 1'b0};

        RST_B = 1'b0; CMD_VLD = 1'b0; CMD_WR = 1'b0; CMD_ADDR = '0; CMD_DATA = '0;
        repeat (3) @(negedge CLK);
        check("rst_strobes", 32'({FCS_B, FLATCH_B, FOE_B, FWE_B}), 32'hF);
        check("rst_ctl", 32'({CFG_DAT_OE, RD_VLD, BUSY, CMD_RDY}), 32'h0);
        check("rst_data", 32'({RD_DATA, CFG_DAT_OUT}), 32'h0);
        check("rst_addr", 32'({FPGA_A22, FPGA_A21, BPI_AD_OUT}), 32'h0);
        RST_B = 1'b1;
        chk_en = 1'b1;
        @(negedge CLK);
        check("rdy_after_release", 32'(CMD_RDY), 32'd1);

        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i], $sformatf("vec%0d", i));
        end

        // Held CMD_VLD: three back-to-back reads, accepted only from idle.
        @(negedge CLK);
        CMD_VLD = 1'b1; CMD_WR = 1'b0; CMD_ADDR = 23'h7F8000; CMD_DATA = 16'h0;
        acc = 0; cyc = 0; n_vld = 0;
        while (acc < 3 && cyc < 100) begin
            if (CMD_RDY) begin
                acc_at[acc] = cyc;
                acc++;
            end
            @(negedge CLK);
            cyc++;
            if (RD_VLD) begin
                n_vld++;
                check("b2b_rd_data", 32'(RD_DATA), 32'h506B);
            end
        end
        CMD_VLD = 1'b0;
        repeat (20) begin
            @(negedge CLK);
            if (RD_VLD) begin
                n_vld++;
                check("b2b_rd_data", 32'(RD_DATA), 32'h506B);
            end
        end
        check("b2b_accepts", 32'(acc), 32'd3);
        if (acc == 3) begin
            check("b2b_spacing_1", 32'(acc_at[1] - acc_at[0]), 32'(SPACING));
            check("b2b_spacing_2", 32'(acc_at[2] - acc_at[1]), 32'(SPACING));
        end
        check("b2b_rdvld_pulses", 32'(n_vld), 32'd3);

        // Reset asserted during the second READ cycle.
        @(negedge CLK);
        CMD_VLD = 1'b1; CMD_WR = 1'b0; CMD_ADDR = 23'h7F8000;
        @(negedge CLK);
        CMD_VLD = 1'b0;
        repeat (T_LATCH + 1) @(negedge CLK);
        check("abort_in_read", 32'(FOE_B), 32'd0);
        #2 RST_B = 1'b0;
        #1;
        check("abort_strobes", 32'({FCS_B, FLATCH_B, FOE_B, FWE_B}), 32'hF);
        check("abort_ctl", 32'({CFG_DAT_OE, RD_VLD, BUSY, CMD_RDY}), 32'h0);
        check("abort_rd_data", 32'(RD_DATA), 32'h0);
        check("abort_addr", 32'({FPGA_A22, FPGA_A21, BPI_AD_OUT}), 32'h0);
        repeat (2) @(negedge CLK);
        RST_B = 1'b1;
        @(negedge CLK);
        check("abort_rdy_first_edge", 32'(CMD_RDY), 32'd1);
        bad = 0;
        repeat (10) begin
            if (RD_VLD || BUSY || ({FCS_B, FLATCH_B, FOE_B, FWE_B} != 4'hF)) bad++;
            @(negedge CLK);
        end
        check("abort_quiet", 32'(bad), 32'd0);

        // Fresh read after the abort completes normally.
        run_cmd(vecs[1], "post_abort");

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bpi_flash_if.md
BPI_FLASH_IF -- requirements
Module: bpi_flash_if

Interface
REQ-001 SHALL have parameter T_LATCH, default 2, cycles FLATCH_B/FCS_B held low for address latch (min 1).
REQ-002 SHALL have parameter T_WR, default 3, cycles FWE_B held low (min 1).
REQ-003 SHALL have parameter T_RD, default 4, cycles FOE_B held low before read capture (min 1; 4 x 24 ns covers 85 ns access).
REQ-004 SHALL have parameter T_REC, default 1, cycles all strobes high after each access (min 1).
REQ-005 Ports SHALL be as follows; one clock, reset asynchronous and active-low:
- CLK  in  1  system clock
- RST_B  in  1  asynchronous active-low reset
- CMD_VLD  in  1  command offered
- CMD_RDY  out  1  command accepted this cycle when high with CMD_VLD
- CMD_WR  in  1  1=write, 0=read
- CMD_ADDR  in  23  flash word address
- CMD_DATA  in  16  write data
- RD_DATA  out  16  captured read word
- RD_VLD  out  1  one-cycle read-complete pulse
- BUSY  out  1  access in progress
- BPI_AD_OUT  out  21  address bits [20:0]
- FPGA_A21, FPGA_A22  out  1 each  address bits 21, 22
- FCS_B, FLATCH_B, FOE_B, FWE_B  out  1 each  active-low flash strobes
- CFG_DAT_IN  in  16  flash data bus input
- CFG_DAT_OUT  out  16  flash data bus drive value
- CFG_DAT_OE  out  1  tristate enable for CFG_DAT_OUT

Function
REQ-006 SHALL implement states IDLE, LATCH, WRITE, READ, RECOVER with a down-counter timing each state.
REQ-007 CMD_RDY SHALL be high only in IDLE; command accepted on rising CLK with CMD_VLD&CMD_RDY; IDLE->LATCH.
REQ-008 At accept SHALL register CMD_WR, CMD_ADDR, CMD_DATA; later input changes ignored until next accept.
REQ-009 BPI_AD_OUT/FPGA_A21/FPGA_A22 SHALL present registered ADDR[20:0]/[21]/[22] from LATCH through RECOVER; hold last value in IDLE.
REQ-010 LATCH: FCS_B=0, FLATCH_B=0 for exactly T_LATCH cycles; then WRITE if CMD_WR else READ.
REQ-011 FCS_B SHALL stay 0 through LATCH, WRITE, READ; FLATCH_B=1 outside LATCH.
REQ-012 WRITE: FWE_B=0, CFG_DAT_OE=1, CFG_DAT_OUT=registered data for T_WR cycles; then RECOVER.
REQ-013 READ: FOE_B=0, CFG_DAT_OE=0 for T_RD cycles; RD_DATA SHALL capture CFG_DAT_IN on the edge ending READ.
REQ-014 RD_VLD SHALL pulse high one cycle, first cycle of RECOVER after a read; never after a write.
REQ-015 RECOVER: FCS_B, FOE_B, FWE_B, FLATCH_B all 1, CFG_DAT_OE=0 for T_REC cycles; then IDLE.
REQ-016 Read latency accept-edge to RD_VLD high SHALL be T_LATCH+T_RD cycles; command-to-command spacing T_LATCH+T_x+T_REC+1.
REQ-017 BUSY SHALL be high in every state except IDLE.
REQ-018 FOE_B and FWE_B SHALL never be low simultaneously; CFG_DAT_OE SHALL never be high while FOE_B is low.
REQ-019 CMD_VLD while not IDLE SHALL be ignored (no queueing); held CMD_VLD accepted on first IDLE cycle.

Reset
REQ-020 RST_B low SHALL asynchronously force IDLE, FCS_B/FLATCH_B/FOE_B/FWE_B=1, CFG_DAT_OE=0, RD_VLD=0, BUSY=0, CMD_RDY=0.
REQ-021 Reset SHALL clear RD_DATA, CFG_DAT_OUT, address outputs to 0; CMD_RDY=1 from first edge after release.
REQ-022 Reset mid-access SHALL abort without RD_VLD and without any further strobe activity.

Configuration
REQ-023 Macro BPI_RD_INREG_EN SHALL, when defined, register CFG_DAT_IN every cycle and extend READ by one cycle, capturing the registered value; read latency becomes T_LATCH+T_RD+1.
REQ-024 Without BPI_RD_INREG_EN, RD_DATA SHALL capture CFG_DAT_IN directly per REQ-013.

Verification
REQ-025 Defaults; write addr 0x7F8000 data 0xA5C3 -> FLATCH_B low 2 cycles, FWE_B low 3 cycles, CFG_DAT_OUT=0xA5C3, FPGA_A22=1, A21=1, BPI_AD_OUT=0x1F8000.
REQ-026 Model returning 0x506B after 85 ns of FOE_B low; read 0x7F8000 -> RD_VLD 6 cycles after accept, RD_DATA=0x506B.
REQ-027 CMD_VLD held high with 3 back-to-back reads -> each accepted only in IDLE, spacing 8 cycles, 3 RD_VLD pulses.
REQ-028 RST_B low during READ cycle 2 -> all strobes 1 immediately, no RD_VLD, CMD_RDY=1 first edge after release.
REQ-029 BPI_RD_INREG_EN defined, same read -> RD_VLD 7 cycles after accept, RD_DATA=0x506B.
REQ-030 Assertion over all scenarios: FOE_B&FWE_B never both 0; CFG_DAT_OE never 1 with FOE_B 0.
